// File: rtl/mux_gate_level_pkg.sv
// Shared constants for the gate-level 2:1 mux block.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Holds the default data width, the default sel transition counter width
// and the saturation value of the counter at its default width.
package mux_gate_level_pkg;

  // Default data width of a, b, out and out_q.
  localparam int MGL_WIDTH_DEF = 1;

  // Default width of the sel transition counter.
  localparam int MGL_CNT_W_DEF = 8;

  // Counter saturation value at the default counter width (all ones).
  localparam logic [MGL_CNT_W_DEF-1:0] MGL_SEL_CNT_SAT = '1;

endpackage : mux_gate_level_pkg

// File: rtl/mux_gate_level_mux2_cell.sv
// One-bit 2:1 mux built strictly from NOT/AND/OR gate primitives.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no flow control on a combinational cell.
//
// Ports:
//   a   - data bit passed to y when sel=1
//   b   - data bit passed to y when sel=0
//   sel - select line
//   y   - (a AND sel) OR (b AND NOT sel)
//
// Gate primitives are used on purpose: an unknown sel propagates through the
// gates as X instead of being resolved the way a conditional operator would.
module mux2_cell (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  wire sel_n;
  wire a_gated;
  wire b_gated;

  not u_not_sel (sel_n, sel);
  and u_and_a   (a_gated, a, sel);
  and u_and_b   (b_gated, b, sel_n);
  or  u_or_y    (y, a_gated, b_gated);

endmodule : mux2_cell

// File: rtl/mux_gate_level.sv
// Gate-level WIDTH-bit 2:1 mux with a registered copy and optional sel counter.
// Latency: out is combinational (0 cycles); out_q and sel_cnt are 1 cycle.
// Backpressure: none; every clock edge captures, no stall path exists.
//
// Ports:
//   clk     - rising-edge clock for all registered state
//   rst     - synchronous, active-high reset (clears out_q and sel_cnt)
//   out     - combinational mux result, unaffected by clk/rst
//   a       - data selected when sel=1
//   b       - data selected when sel=0
//   sel     - select line
//   out_q   - out registered on every rising edge
//   sel_cnt - saturating count of sel transitions, only when the macro
//             MUX_GATE_LEVEL_SELCNT_EN is defined
module mux_gate_level
  import mux_gate_level_pkg::*;
#(
  parameter int WIDTH = MGL_WIDTH_DEF,
  parameter int CNT_W = MGL_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out_q
`ifdef MUX_GATE_LEVEL_SELCNT_EN
  ,
  output logic [CNT_W-1:0] sel_cnt
`endif
);

  // One gate-level cell per data bit; all cells share the select line.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux2_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .sel (sel),
      .y   (out[i])
    );
  end

  // Registered copy of the combinational result.
  logic [WIDTH-1:0] out_reg_d;
  logic [WIDTH-1:0] out_reg_q;

  assign out_reg_d = out;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg_q <= '0;
    end else begin
      out_reg_q <= out_reg_d;
    end
  end

  assign out_q = out_reg_q;

`ifdef MUX_GATE_LEVEL_SELCNT_EN
  // Transition counter. The registered sel clears to 0 in reset, so a sel
  // held high through reset is counted once at the first edge afterwards.
  localparam logic [CNT_W-1:0] SEL_CNT_SAT = '1;

  logic             sel_q;
  logic [CNT_W-1:0] sel_cnt_d;
  logic [CNT_W-1:0] sel_cnt_q;

  always_comb begin
    sel_cnt_d = sel_cnt_q;
    if ((sel != sel_q) && (sel_cnt_q != SEL_CNT_SAT)) begin
      sel_cnt_d = sel_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= 1'b0;
      sel_cnt_q <= '0;
    end else begin
      sel_q     <= sel;
      sel_cnt_q <= sel_cnt_d;
    end
  end

  assign sel_cnt = sel_cnt_q;
`else
  // Counter width has no consumer when the counter is compiled out.
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule : mux_gate_level

// File: tb/tb_mux_gate_level.sv
// Self-checking bench for mux_gate_level: a 1-bit and an 8-bit instance
// share clk/rst/sel and are compared against a behavioural model built from
// "sel picks a else b", "out_q is last edge's out", and a saturating count.
module tb_mux_gate_level;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic [0:0] a1, b1, out1, outq1;
  logic [7:0] a8, b8, out8, outq8;
`ifdef MUX_GATE_LEVEL_SELCNT_EN
  logic [7:0] cnt1;
  logic [1:0] cnt8;
`endif

  always #5 clk = ~clk;

  mux_gate_level #(.WIDTH(1), .CNT_W(8)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .out     (out1),
    .a       (a1),
    .b       (b1),
    .sel     (sel),
    .out_q   (outq1)
`ifdef MUX_GATE_LEVEL_SELCNT_EN
    ,
    .sel_cnt (cnt1)
`endif
  );

  mux_gate_level #(.WIDTH(8), .CNT_W(2)) u_dut8 (
    .clk     (clk),
    .rst     (rst),
    .out     (out8),
    .a       (a8),
    .b       (b8),
    .sel     (sel),
    .out_q   (outq8)
`ifdef MUX_GATE_LEVEL_SELCNT_EN
    ,
    .sel_cnt (cnt8)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model state
  logic [0:0] exp_q1;
  logic [7:0] exp_q8;
  bit         q_known = 1'b0;
  int         m_cnt1  = 0;
  int         m_cnt8  = 0;
  logic       m_sel_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply new inputs, then check the combinational result 1 ns later and
  // that the registered output has not moved.
  task automatic drive(input logic s, input logic [7:0] va8, input logic [7:0] vb8,
                       input logic va1, input logic vb1);
    sel = s; a8 = va8; b8 = vb8; a1 = va1; b1 = vb1;
    #1;
    chk("out1", 32'(out1), 32'(s ? va1 : vb1));
    chk("out8", 32'(out8), 32'(s ? va8 : vb8));
    if (q_known) begin
      chk("out_q1_hold", 32'(outq1), 32'(exp_q1));
      chk("out_q8_hold", 32'(outq8), 32'(exp_q8));
    end
  endtask

  // One rising edge with the current inputs; update the model and check.
  task automatic tick();
    logic [0:0] n1;
    logic [7:0] n8;
    n1 = rst ? 1'b0 : (sel ? a1 : b1);
    n8 = rst ? 8'h00 : (sel ? a8 : b8);
    if (rst) begin
      m_cnt1 = 0; m_cnt8 = 0; m_sel_prev = 1'b0;
    end else begin
      if (sel != m_sel_prev) begin
        m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
        m_cnt8 = (m_cnt8 < 3) ? m_cnt8 + 1 : 3;
      end
      m_sel_prev = sel;
    end
    @(posedge clk);
    #1;
    exp_q1 = n1; exp_q8 = n8; q_known = 1'b1;
    chk("out_q1", 32'(outq1), 32'(exp_q1));
    chk("out_q8", 32'(outq8), 32'(exp_q8));
`ifdef MUX_GATE_LEVEL_SELCNT_EN
    chk("sel_cnt1", 32'(cnt1), 32'(m_cnt1));
    chk("sel_cnt8", 32'(cnt8), 32'(m_cnt8));
`endif
  endtask

  initial begin
    rst = 1'b1;
    // Comb select a / b / a again, before any clock edge.
    drive(1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0);
    drive(1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0);
    drive(1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0);

    // Reset for two edges with a=1, sel=1: out_q stays 0, out stays 1.
    tick();
    chk("rst_out1", 32'(out1), 32'd1);
    tick();
    chk("rst_q1", 32'(outq1), 32'd0);
    chk("rst_out8", 32'(out8), 32'hA5);
`ifdef MUX_GATE_LEVEL_SELCNT_EN
    chk("rst_cnt1", 32'(cnt1), 32'd0);
`endif

    // Release reset: first edge captures current out; sel held 1 counts once.
    rst = 1'b0;
    tick();
    chk("post_rst_q1", 32'(outq1), 32'd1);

    // sel 1 -> 0 between edges: out moves now, out_q one edge later.
    drive(1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0);
    chk("lat_q_old", 32'(outq1), 32'd1);
    tick();
    chk("lat_q_new", 32'(outq1), 32'd0);
    drive(1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0);
    tick();

    // Five toggles from reset: 8-bit-wide instance's 2-bit counter holds 3.
    rst = 1'b1;
    drive(1'b0, 8'h0F, 8'hF0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(~sel, 8'(i * 37), 8'(i * 91 + 3), 1'(i), 1'(~i));
      tick();
    end
`ifdef MUX_GATE_LEVEL_SELCNT_EN
    chk("sat_cnt8", 32'(cnt8), 32'd3);
    chk("cnt1_5", 32'(cnt1), 32'd5);
`endif

    // Randomized run with occasional mid-operation resets.
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      drive(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      tick();
      if (rst) chk("mid_rst_q8", 32'(outq8), 32'd0);
    end

    // Long toggle run: 8-bit counter of the narrow instance saturates.
    rst = 1'b0;
    for (int i = 0; i < 270; i++) begin
      drive(~sel, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mux_gate_level

// File: doc/mux_gate_level.md
MUX_GATE_LEVEL -- requirements
Module: mux_gate_level

Interface
REQ-001 Parameter WIDTH, default 1, data width of a, b, out, out_q.
REQ-002 Parameter CNT_W, default 8, width of sel_cnt.
REQ-003 Clocking SHALL be one clock with a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all registered state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 out  output  WIDTH  combinational mux result.
REQ-007 a  input  WIDTH  data input selected when sel=1.
REQ-008 b  input  WIDTH  data input selected when sel=0.
REQ-009 sel  input  1  select line.
REQ-010 out_q  output  WIDTH  registered copy of out.
REQ-011 sel_cnt  output  CNT_W  sel transition count; present only with the macro in REQ-025.
REQ-012 Port declaration order SHALL be clk, rst, out, a, b, sel, out_q, then sel_cnt when present.

Function
REQ-013 out SHALL equal a bitwise when sel=1 and b bitwise when sel=0, per bit out = (a AND sel) OR (b AND NOT sel).
REQ-014 out SHALL be purely combinational, with zero clock latency and no dependence on clk or rst.
REQ-015 out SHALL settle within the same timestep as any change on a, b, or sel, so a sample 1 ns after the change sees the new value.
REQ-016 out_q SHALL capture out on every rising clk edge when rst=0, giving one-cycle latency.
REQ-017 When a, b, and sel change in the same cycle, out_q SHALL reflect the combined new value at the next edge.
REQ-018 sel=X or Z SHALL NOT be resolved by the design; gate semantics propagate X, and no X-masking logic is added.
REQ-019 The comb path SHALL be built only from NOT, AND, and OR gate primitives, with no conditional operator and no behavioural case.

Reset
REQ-020 Reset SHALL be synchronous and active-high: rst sampled high at a rising clk edge sets out_q to 0 and sel_cnt to 0.
REQ-021 out SHALL be unaffected by rst at all times.
REQ-022 On reset asserted mid-operation, out_q SHALL be 0 at the first edge with rst=1 and SHALL hold 0 while rst stays high.
REQ-023 On the first edge after rst deasserts, out_q SHALL capture the current out.
REQ-024 No output SHALL have an undefined value after the first reset edge.

Configuration
REQ-025 Macro MUX_GATE_LEVEL_SELCNT_EN SHALL control the sel transition counter.
REQ-026 With MUX_GATE_LEVEL_SELCNT_EN defined, the block SHALL register sel each edge and increment sel_cnt on each edge where sel differs from its registered value.
REQ-027 sel_cnt SHALL saturate at all-ones and SHALL not wrap.
REQ-028 The registered sel value SHALL reset to 0, so a sel held at 1 through reset counts as one transition at the first edge after reset.
REQ-029 Without MUX_GATE_LEVEL_SELCNT_EN, the sel_cnt port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package mux_gate_level_pkg SHALL hold the WIDTH default constant (1), the CNT_W default constant (8), and the sel_cnt saturation value constant.
REQ-031 Sub-module mux2_cell SHALL implement one bit of the gate-level mux (inputs a, b, sel; output y; 1 NOT, 2 AND, 1 OR).
REQ-032 The top SHALL instantiate mux2_cell WIDTH times via generate.
REQ-033 Registers and the counter SHALL reside in the top level.

Verification
REQ-034 Comb select a: WIDTH=1, sel=1, a=1, b=0, check at +1 ns -> out=1.
REQ-035 Comb select b: sel=0, a=1, b=0 -> out=0; then sel=1 again -> out=1 within 1 ns.
REQ-036 Register latency: sel toggles 1->0 between edges -> out_q changes from 1 to 0 exactly one edge later, while out changes immediately.
REQ-037 Reset: rst=1 for 2 edges with a=1, sel=1 -> out_q=0 and out=1 throughout; after rst=0, out_q=1 at the next edge.
REQ-038 Counter (macro on): after reset, sel sequence 1,0,1 on successive edges -> sel_cnt = 1, 2, 3.
REQ-039 Counter saturation (macro on): with CNT_W=2 and 5 toggles -> sel_cnt holds 3.
REQ-040 Width: WIDTH=8, a=8'hA5, b=8'h3C -> sel=1 gives out=8'hA5; sel=0 gives out=8'h3C.
